timer_ctrl: RTL and testbench

- Stable-timer controller for the LoongArch32 CSR file: owns TCFG, sequences the TVAL down-counter, and generates and clears the timer interrupt pending bit TI.
- Handles CSR writes to TCFG/TICLR and provides combinational CSR read data for TCFG/TVAL/TICLR.
- TI feeds ESTAT.IS[11] and the interrupt arbiter.

---
 rtl/timer_ctrl.sv | 100 ++++++++++
 tb/tb_timer_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Stable-timer controller for the LoongArch32 CSR file.
// Owns TCFG, runs the TVAL down-counter and raises/clears the TI pending bit.
module timer_ctrl #(
    parameter logic [13:0] ADDR_TCFG  = 14'h041,
    parameter logic [13:0] ADDR_TVAL  = 14'h042,
    parameter logic [13:0] ADDR_TICLR = 14'h044
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [13:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        ti,
    output logic [1:0]  timer_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] tval_nx;
    logic        ti_nx;
    logic        tcfg_wr;
    logic        ticlr_wr;
    logic        expire;
    logic [31:0] load_val;

    assign tcfg_wr  = csr_we && (csr_waddr == ADDR_TCFG);
    assign ticlr_wr = csr_we && (csr_waddr == ADDR_TICLR) && csr_wdata[0];
    assign load_val = {tcfg[31:2], 2'b00};
    // A TCFG write in the same cycle swallows that cycle's expiry.
    assign expire   = (state == RUN) && (tval == 32'd0) && !tcfg_wr;

    // State, counter, TCFG and TI registers; reset aborts any count in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tcfg  <= 32'd0;
            tval  <= 32'd0;
            ti    <= 1'b0;
        end else begin
            state <= state_nx;
            tval  <= tval_nx;
            ti    <= ti_nx;
            if (tcfg_wr)
                tcfg <= csr_wdata;
        end
    end

    // Next state and next counter value; TCFG writes override counting.
    always_comb begin
        state_nx = state;
        tval_nx  = tval;
        if (tcfg_wr) begin
            state_nx = csr_wdata[0] ? RUN : IDLE;
            tval_nx  = {csr_wdata[31:2], 2'b00};
        end else begin
            case (state)
                RUN: begin
                    if (tval != 32'd0) begin
                        tval_nx = tval - 32'd1;
                    end else if (tcfg[1]) begin
                        tval_nx = load_val;
                    end else begin
                        state_nx = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // TI: expiry sets and wins over a coincident clear.
    always_comb begin
        ti_nx = ti;
        if (expire)
            ti_nx = 1'b1;
        else if (ticlr_wr)
            ti_nx = 1'b0;
    end

    // Combinational CSR read mux; unowned addresses read as zero.
    always_comb begin
        csr_rdata = 32'd0;
        if (csr_raddr == ADDR_TCFG)
            csr_rdata = tcfg;
        else if (csr_raddr == ADDR_TVAL)
            csr_rdata = tval;
    end

    assign timer_state = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl. The reference model tracks only TCFG,
// the number of edges since the last TCFG write, and TI; counter value and
// expiries are derived arithmetically from elapsed time.
module tb_timer_ctrl;

    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_TICLR = 14'h044;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [13:0] csr_waddr = 14'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [13:0] csr_raddr = 14'd0;
    logic [31:0] csr_rdata;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        ti;
    logic [1:0]  timer_state;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model
    logic [31:0]     m_tcfg = 32'd0;
    longint unsigned m_k    = 0;
    logic            m_ti   = 1'b0;

    timer_ctrl dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .tcfg(tcfg), .tval(tval), .ti(ti), .timer_state(timer_state)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned m_load();
        return {32'd0, m_tcfg[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] exp_tval();
        longint unsigned l = m_load();
        if (!m_tcfg[0]) return l[31:0];
        if (m_tcfg[1]) return 32'(l - (m_k % (l + 1)));
        if (m_k >= l) return 32'd0;
        return 32'(l - m_k);
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_tcfg[0]) return 2'd0;
        if (!m_tcfg[1] && m_k > m_load()) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [13:0] a);
        if (a == A_TCFG) return m_tcfg;
        if (a == A_TVAL) return exp_tval();
        return 32'd0;
    endfunction

    // Model one clock edge given the write presented in that cycle.
    function automatic void model_edge(input logic we, input logic [13:0] wa,
                                       input logic [31:0] wd);
        longint unsigned l;
        logic ev;
        if (we && wa == A_TCFG) begin
            m_tcfg = wd;
            m_k    = 0;
        end else begin
            m_k = m_k + 1;
            l   = m_load();
            ev  = m_tcfg[0] && (m_tcfg[1] ? (m_k % (l + 1) == 0) : (m_k == l + 1));
            if (ev) m_ti = 1'b1;
            else if (we && wa == A_TICLR && wd[0]) m_ti = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_tcfg = 32'd0;
        m_k    = 0;
        m_ti   = 1'b0;
    endfunction

    // Present a write (or idle) for one cycle; returns at the following negedge.
    task automatic tick(input logic we, input logic [13:0] wa, input logic [31:0] wd);
        csr_we = we; csr_waddr = wa; csr_wdata = wd;
        @(posedge clk);
        model_edge(we, wa, wd);
        @(negedge clk);
        csr_we = 1'b0; csr_waddr = 14'd0; csr_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 14'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tcfg, tval, ti, timer_state} !== {32'd0, 32'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_state: tcfg=%h tval=%h ti=%b st=%0d, want all zero", tcfg, tval, ti, timer_state);
        end
    endtask

    task automatic test_oneshot();
        csr_raddr = A_TVAL;
        tick(1'b1, A_TCFG, 32'h0000_0005);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tval !== 32'(4 - i) || csr_rdata !== 32'(4 - i) || ti !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_count[%0d]: tval=%0d rdata=%0d ti=%b, want %0d/%0d/0", i, tval, csr_rdata, ti, 4 - i, 4 - i);
            end
            tick(1'b0, 14'd0, 32'd0);
        end
        n_chk++;
        if (ti !== 1'b1 || timer_state !== 2'd2 || tval !== 32'd0) begin
            n_fail++;
            $display("FAIL oneshot_expire: ti=%b st=%0d tval=%0d, want 1/2/0", ti, timer_state, tval);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 14'd0, 32'd0);
            n_chk++;
            if (ti !== 1'b1 || tval !== 32'd0 || timer_state !== 2'd2) begin
                n_fail++;
                $display("FAIL oneshot_hold[%0d]: ti=%b tval=%0d st=%0d, want 1/0/2", i, ti, tval, timer_state);
            end
        end
    endtask

    task automatic test_periodic();
        tick(1'b1, A_TICLR, 32'h1);
        tick(1'b1, A_TCFG, 32'h0000_0007);
        for (int i = 0; i < 22; i++) begin
            n_chk++;
            if (tval !== 32'(4 - (i % 5)) || ti !== m_ti || timer_state !== 2'd1) begin
                n_fail++;
                $display("FAIL periodic[%0d]: tval=%0d ti=%b st=%0d, want %0d/%b/1", i, tval, ti, timer_state, 4 - (i % 5), m_ti);
            end
            if (i == 7 || i == 13) tick(1'b1, A_TICLR, 32'h1);
            else if (i == 16)      tick(1'b1, A_TICLR, 32'h0);
            else                   tick(1'b0, 14'd0, 32'd0);
        end
    endtask

    task automatic test_clear_vs_expire();
        tick(1'b1, A_TCFG, 32'h0000_0007);
        tick(1'b1, A_TICLR, 32'h1);
        idle(3);
        n_chk++;
        if (ti !== 1'b0 || tval !== 32'd0) begin
            n_fail++;
            $display("FAIL clr_pre: ti=%b tval=%0d, want 0/0", ti, tval);
        end
        tick(1'b1, A_TICLR, 32'h1);
        n_chk++;
        if (ti !== 1'b1 || tval !== 32'd4) begin
            n_fail++;
            $display("FAIL clr_vs_expire: ti=%b tval=%0d, want 1/4", ti, tval);
        end
    endtask

    task automatic test_disable();
        logic ti_before;
        tick(1'b1, A_TCFG, 32'h0000_0007);
        idle(2);
        ti_before = m_ti;
        n_chk++;
        if (tval !== 32'd2) begin
            n_fail++;
            $display("FAIL disable_pre: tval=%0d, want 2", tval);
        end
        csr_raddr = A_TCFG;
        csr_we = 1'b1; csr_waddr = A_TCFG; csr_wdata = 32'h0000_0008;
        #1;
        n_chk++;
        if (csr_rdata !== 32'h0000_0007) begin
            n_fail++;
            $display("FAIL read_during_write: rdata=%h, want 00000007", csr_rdata);
        end
        tick(1'b1, A_TCFG, 32'h0000_0008);
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (tval !== 32'd8 || timer_state !== 2'd0 || ti !== ti_before || tcfg !== 32'h8) begin
                n_fail++;
                $display("FAIL disable_hold[%0d]: tval=%0d st=%0d ti=%b tcfg=%h, want 8/0/%b/8", i, tval, timer_state, ti, tcfg, ti_before);
            end
            tick(1'b0, 14'd0, 32'd0);
        end
    endtask

    task automatic test_zero_period();
        tick(1'b1, A_TICLR, 32'h1);
        tick(1'b1, A_TCFG, 32'h0000_0003);
        n_chk++;
        if (ti !== 1'b0 || tval !== 32'd0 || timer_state !== 2'd1) begin
            n_fail++;
            $display("FAIL zero_first: ti=%b tval=%0d st=%0d, want 0/0/1", ti, tval, timer_state);
        end
        // This edge would expire, but the TCFG write suppresses it.
        tick(1'b1, A_TCFG, 32'h0000_0003);
        n_chk++;
        if (ti !== 1'b0) begin
            n_fail++;
            $display("FAIL write_in_expire: ti=%b, want 0", ti);
        end
        tick(1'b0, 14'd0, 32'd0);
        n_chk++;
        if (ti !== 1'b1 || tval !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_expire: ti=%b tval=%0d, want 1/0", ti, tval);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, A_TICLR, 32'h1);
            n_chk++;
            if (ti !== 1'b1 || timer_state !== 2'd1) begin
                n_fail++;
                $display("FAIL zero_every_cycle[%0d]: ti=%b st=%0d, want 1/1", i, ti, timer_state);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, A_TCFG, 32'h0000_0007);
        idle(6);
        n_chk++;
        if (tval !== 32'd3 || ti !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: tval=%0d ti=%b, want 3/1", tval, ti);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({tcfg, tval, ti, timer_state} !== {32'd0, 32'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL arst_async: tcfg=%h tval=%h ti=%b st=%0d, want all zero", tcfg, tval, ti, timer_state);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, A_TVAL, 32'hFFFF_FFFF);
        n_chk++;
        if (tval !== 32'd0 || tcfg !== 32'd0 || timer_state !== 2'd0) begin
            n_fail++;
            $display("FAIL tval_write_ignored: tval=%h tcfg=%h st=%0d, want 0/0/0", tval, tcfg, timer_state);
        end
        tick(1'b1, A_TCFG, 32'h0000_0011);
        csr_raddr = A_TICLR;
        #1;
        n_chk++;
        if (csr_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL ticlr_read: rdata=%h, want 0", csr_rdata);
        end
        csr_raddr = 14'h123;
        #1;
        n_chk++;
        if (csr_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL unowned_read: rdata=%h, want 0", csr_rdata);
        end
    endtask

    task automatic test_random();
        logic [13:0] addrs [4];
        logic [31:0] wd;
        logic [13:0] wa;
        int          sel;
        addrs[0] = A_TCFG; addrs[1] = A_TVAL; addrs[2] = A_TICLR; addrs[3] = 14'h040;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                wd = {26'($urandom_range(0, 0)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                wd[31:2] = 30'($urandom_range(0, 3));
                wd[1:0]  = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) wd[0] = 1'b0;
                else wd[0] = 1'b1;
                tick(1'b1, A_TCFG, wd);
            end else if (sel < 4) begin
                tick(1'b1, A_TICLR, 32'($urandom_range(0, 3)));
            end else if (sel == 4) begin
                wa = addrs[$urandom_range(1, 3)];
                tick(1'b1, wa, $urandom());
            end else begin
                tick(1'b0, 14'd0, 32'd0);
            end
            csr_raddr = addrs[$urandom_range(0, 3)];
            #1;
            n_chk++;
            if (tval !== exp_tval() || ti !== m_ti || timer_state !== exp_state() ||
                tcfg !== m_tcfg || csr_rdata !== exp_rdata(csr_raddr)) begin
                n_fail++;
                $display("FAIL random[%0d]: tval=%h/%h ti=%b/%b st=%0d/%0d tcfg=%h/%h rdata=%h/%h (got/want)",
                         i, tval, exp_tval(), ti, m_ti, timer_state, exp_state(), tcfg, m_tcfg,
                         csr_rdata, exp_rdata(csr_raddr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_clear_vs_expire();
        test_disable();
        test_zero_period();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
